// File: rtl/ccd_readout_sampler.sv
// CCD receive-side CDS sampler: follows the phi_r/phi_l1/phi_p phases, drives the ADC for reset and
// signal levels, and hands (reset - signal) pixels tagged with row/column to the frame buffer.
module ccd_readout_sampler #(
    parameter int ADC_W  = 12,
    parameter int COLS   = 8,
    parameter int ROWS   = 8,
    parameter int SETTLE = 2,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phi_p,
    input  logic             phi_l1,
    input  logic             phi_l2,
    input  logic             phi_r,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] pix_data,
    output logic [COL_W-1:0] pix_col,
    output logic [ROW_W-1:0] pix_row,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             line_end,
    output logic             ovf,
    output logic             seq_err,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_RF = 3'd1;
    localparam logic [2:0] SET_R   = 3'd2;
    localparam logic [2:0] CONV_R  = 3'd3;
    localparam logic [2:0] WAIT_L1 = 3'd4;
    localparam logic [2:0] SET_S   = 3'd5;
    localparam logic [2:0] CONV_S  = 3'd6;

    localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    // Handshake: a pixel moves on any rising clk edge where pix_valid && pix_ready; while pix_valid is
    // high and pix_ready is low, pix_data/pix_col/pix_row/line_end hold their values.

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ADC_W-1:0] rst_lvl_q, rst_lvl_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ADC_W-1:0] pix_data_q, pix_data_d;
    logic [COL_W-1:0] pix_col_q, pix_col_d;
    logic [ROW_W-1:0] pix_row_q, pix_row_d;
    logic             pix_valid_q, pix_valid_d;
    logic             line_end_q, line_end_d;
    logic             ovf_q, ovf_d;
    logic             seq_err_q, seq_err_d;
    logic             phi_p_q, phi_l1_q, phi_l2_q, phi_r_q;

    logic             r_rise, r_fall, l1_rise, l2_rise, p_rise;
    logic [ADC_W:0]   diff;
    logic [ADC_W-1:0] cds;

    assign r_rise  = phi_r  & ~phi_r_q;
    assign r_fall  = ~phi_r & phi_r_q;
    assign l1_rise = phi_l1 & ~phi_l1_q;
    assign l2_rise = phi_l2 & ~phi_l2_q;
    assign p_rise  = phi_p  & ~phi_p_q;

    // One extra bit catches signal > reset so the result clamps to zero instead of wrapping.
    assign diff = {1'b0, rst_lvl_q} - {1'b0, adc_data};
    assign cds  = diff[ADC_W] ? '0 : diff[ADC_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_lvl_d   = rst_lvl_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_data_d  = pix_data_q;
        pix_col_d   = pix_col_q;
        pix_row_d   = pix_row_q;
        pix_valid_d = pix_valid_q;
        line_end_d  = line_end_q;
        ovf_d       = ovf_q;
        seq_err_d   = seq_err_q;

        if (pix_valid_q && pix_ready) begin
            pix_valid_d = 1'b0;
        end
        if (l2_rise && phi_l1) begin
            seq_err_d = 1'b1;
        end

        if (p_rise) begin
            col_d   = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            state_d = IDLE;
        end else if (r_rise && (state_q != IDLE) && (state_q != WAIT_RF)) begin
            seq_err_d = 1'b1;
            state_d   = WAIT_RF;
        end else begin
            case (state_q)
                IDLE:    if (r_rise) state_d = WAIT_RF;
                WAIT_RF: if (r_fall) begin
                    state_d = SET_R;
                    cnt_d   = '0;
                end
                SET_R:   if (cnt_q == SETTLE_C) state_d = CONV_R;
                         else cnt_d = cnt_q + 4'd1;
                CONV_R:  if (l1_rise) begin
                    seq_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (adc_done) begin
                    rst_lvl_d = adc_data;
                    state_d   = WAIT_L1;
                end
                WAIT_L1: if (l1_rise) begin
                    state_d = SET_S;
                    cnt_d   = '0;
                end
                SET_S:   if (cnt_q == SETTLE_C) state_d = CONV_S;
                         else cnt_d = cnt_q + 4'd1;
                CONV_S:  if (adc_done) begin
                    state_d = IDLE;
                    col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                    if (!pix_valid_q || pix_ready) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = cds;
                        pix_col_d   = col_q;
                        pix_row_d   = row_q;
                        line_end_d  = (col_q == COL_LAST);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rst_lvl_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_data_q  <= '0;
            pix_col_q   <= '0;
            pix_row_q   <= '0;
            pix_valid_q <= 1'b0;
            line_end_q  <= 1'b0;
            ovf_q       <= 1'b0;
            seq_err_q   <= 1'b0;
            phi_p_q     <= 1'b0;
            phi_l1_q    <= 1'b0;
            phi_l2_q    <= 1'b0;
            phi_r_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_lvl_q   <= rst_lvl_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_data_q  <= pix_data_d;
            pix_col_q   <= pix_col_d;
            pix_row_q   <= pix_row_d;
            pix_valid_q <= pix_valid_d;
            line_end_q  <= line_end_d;
            ovf_q       <= ovf_d;
            seq_err_q   <= seq_err_d;
            phi_p_q     <= phi_p;
            phi_l1_q    <= phi_l1;
            phi_l2_q    <= phi_l2;
            phi_r_q     <= phi_r;
        end
    end

    // Conversion request is decoded from registered state so it is a clean one-cycle pulse.
    assign adc_start = ((state_q == SET_R) || (state_q == SET_S)) && (cnt_q == SETTLE_C);
    assign pix_data  = pix_data_q;
    assign pix_col   = pix_col_q;
    assign pix_row   = pix_row_q;
    assign pix_valid = pix_valid_q;
    assign line_end  = line_end_q;
    assign ovf       = ovf_q;
    assign seq_err   = seq_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ccd_readout_sampler.sv
// Directed bench for ccd_readout_sampler: phase-pattern driver, 3-cycle ADC model, pixel scoreboard
// built from CDS arithmetic and column/row counting, plus literal spot checks.
module tb_ccd_readout_sampler;

    localparam int ADC_W   = 12;
    localparam int COLS    = 8;
    localparam int ROWS    = 8;
    localparam int SETTLE  = 2;
    localparam int PER     = 20;  // phi_r high cycles 0..2, phi_l1 high 10..17, phi_l2 high 0..7
    localparam int ADC_LAT = 3;
    localparam int K_OK = 0, K_DROP = 1, K_ABORT = 2, K_RESET = 3;

    logic             clk, rst_n;
    logic             phi_p, phi_l1, phi_l2, phi_r;
    logic             adc_start, adc_done;
    logic [ADC_W-1:0] adc_data, pix_data;
    logic [2:0]       pix_col, pix_row, dbg_state;
    logic             pix_valid, pix_ready, line_end, ovf, seq_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_r0 = 0;
    int          adc_cd  = 0;
    int          adc_q[$];
    int          start_cyc[$];
    logic [18:0] exp_q[$];
    int          m_col = 0;
    int          m_row = 0;
    bit          m_ovf = 0;
    bit          m_seq = 0;
    bit          prev_hold = 0;
    logic [18:0] prev_out;

    ccd_readout_sampler #(.ADC_W(ADC_W), .COLS(COLS), .ROWS(ROWS), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .phi_p(phi_p), .phi_l1(phi_l1), .phi_l2(phi_l2), .phi_r(phi_r),
        .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .pix_data(pix_data), .pix_col(pix_col), .pix_row(pix_row), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .line_end(line_end), .ovf(ovf), .seq_err(seq_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- ADC model ----------------
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(posedge clk);
            #2;
            adc_done = 1'b0;
            if (adc_cd > 0) begin
                adc_cd--;
                if (adc_cd == 0) begin
                    adc_done = 1'b1;
                    adc_data = (adc_q.size() > 0) ? 12'(adc_q.pop_front()) : 12'h000;
                end
            end
            if (adc_start) begin
                adc_cd = ADC_LAT;
                start_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int cds(input int r, input int s);
        return (r >= s) ? r - s : 0;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pixel(input int rst_v, input int sig_v, input int kind,
                         input int l1_at, input int rst_at, input bit l2_ovl);
        adc_q.push_back(rst_v);
        if (kind != K_ABORT) adc_q.push_back(sig_v);
        case (kind)
            K_OK: begin
                exp_q.push_back({1'(m_col == COLS - 1), 3'(m_row), 3'(m_col), 12'(cds(rst_v, sig_v))});
                m_col = (m_col + 1) % COLS;
            end
            K_DROP: begin
                m_ovf = 1;
                m_col = (m_col + 1) % COLS;
            end
            K_ABORT: m_seq = 1;
            default: begin
                m_col = 0;
                m_row = 0;
                m_ovf = 0;
                m_seq = 0;
            end
        endcase
        if (l2_ovl) m_seq = 1;
        last_r0 = cyc;
        for (int k = 0; k < PER; k++) begin
            phi_r  = (k < 3);
            phi_l1 = (k >= l1_at) && (k < 18);
            phi_l2 = (k < 8) || (l2_ovl && k >= 12 && k < 14);
            phi_p  = 1'b0;
            rst_n  = (k != rst_at);
            step(1);
        end
    endtask

    task automatic line_pulse();
        phi_r  = 1'b0;
        phi_l1 = 1'b0;
        phi_l2 = 1'b0;
        phi_p  = 1'b1;
        step(2);
        phi_p = 1'b0;
        step(2);
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
    endtask

    task automatic release_slot();
        pix_ready = 1'b1;
        step(1);
        pix_ready = 1'b0;
    endtask

    task automatic check_flags();
        chk("ovf", ovf, longint'(m_ovf));
        chk("seq_err", seq_err, longint'(m_seq));
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("valid_held", pix_valid, 1);
                chk("held_stable", {line_end, pix_row, pix_col, pix_data}, prev_out);
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", {line_end, pix_row, pix_col, pix_data}, 19'h7ffff);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    chk("pix_data", pix_data, e[11:0]);
                    chk("pix_col", pix_col, e[14:12]);
                    chk("pix_row", pix_row, e[17:15]);
                    chk("line_end", line_end, e[18]);
                end
            end
            prev_hold = pix_valid && !pix_ready;
            prev_out  = {line_end, pix_row, pix_col, pix_data};
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; phi_p = 1'b0; phi_l1 = 1'b0; phi_l2 = 1'b0; phi_r = 1'b0; pix_ready = 1'b0;
        step(3);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_pix_col", pix_col, 0);
        chk("rst_pix_row", pix_row, 0);
        chk("rst_line_end", line_end, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_adc_start", adc_start, 0);
        rst_n = 1'b1;
        step(2);

        // Nominal pixel, held until ready
        start_cyc.delete();
        pixel(12'hC80, 12'h400, K_OK, 10, -1, 0);
        chk("adc_start_count", start_cyc.size(), 2);
        chk("adc_start_reset_lvl", (start_cyc.size() > 0) ? start_cyc[0] - last_r0 : -1, 6);
        chk("adc_start_signal_lvl", (start_cyc.size() > 1) ? start_cyc[1] - last_r0 : -1, 13);
        chk("nom_valid", pix_valid, 1);
        chk("nom_data", pix_data, 12'h880);
        chk("nom_col", pix_col, 0);
        chk("nom_row", pix_row, 0);
        step(2);
        chk("nom_valid_held", pix_valid, 1);
        release_slot();
        chk("nom_valid_after_accept", pix_valid, 0);

        // Saturation and extremes
        pixel(12'h100, 12'h300, K_OK, 10, -1, 0);
        chk("sat_data", pix_data, 12'h000);
        chk("sat_col", pix_col, 1);
        release_slot();
        pixel(12'hFFF, 12'h000, K_OK, 10, -1, 0);
        chk("max_data", pix_data, 12'hFFF);
        release_slot();
        pixel(12'h555, 12'h555, K_OK, 10, -1, 0);
        chk("equal_data", pix_data, 12'h000);
        release_slot();

        // Line wrap: nine pixels on one line, then rows wrap back to 0
        pix_ready = 1'b1;
        line_pulse();
        for (int i = 0; i < 9; i++) begin
            pix_ready = (i != 7);
            pixel(12'h800 + i * 12'h031, i * 12'h120, K_OK, 10, -1, 0);
            if (i == 7) begin
                chk("col7_line_end", line_end, 1);
                chk("col7_col", pix_col, 7);
                chk("col7_row", pix_row, 1);
                release_slot();
            end
        end
        for (int i = 0; i < 7; i++) line_pulse();
        pix_ready = 1'b0;
        pixel(12'h300, 12'h100, K_OK, 10, -1, 0);
        chk("rowwrap_row", pix_row, 0);
        chk("rowwrap_col", pix_col, 0);
        chk("rowwrap_data", pix_data, 12'h200);
        release_slot();

        // Backpressure: second pixel dropped while first is held
        pixel(12'hA00, 12'h200, K_OK, 10, -1, 0);
        pixel(12'h900, 12'h100, K_DROP, 10, -1, 0);
        chk("bp_ovf", ovf, 1);
        chk("bp_valid", pix_valid, 1);
        chk("bp_col", pix_col, 1);
        chk("bp_data", pix_data, 12'h800);
        release_slot();
        pix_ready = 1'b1;
        pixel(12'h700, 12'h050, K_OK, 10, -1, 0);
        check_flags();

        // Sequence error: phi_l1 rises during the reset-level conversion
        pixel(12'h600, 12'h000, K_ABORT, 8, -1, 0);
        check_flags();
        chk("seq_no_pixel", pix_valid, 0);
        pixel(12'h650, 12'h050, K_OK, 10, -1, 0);

        // Reset during signal conversion, adc_done arrives afterwards
        pixel(12'h400, 12'h100, K_RESET, 10, 14, 0);
        chk("rmid_valid", pix_valid, 0);
        chk("rmid_data", pix_data, 0);
        chk("rmid_col", pix_col, 0);
        chk("rmid_row", pix_row, 0);
        chk("rmid_line_end", line_end, 0);
        check_flags();
        pix_ready = 1'b0;
        pixel(12'h321, 12'h021, K_OK, 10, -1, 0);
        chk("post_rst_col", pix_col, 0);
        chk("post_rst_data", pix_data, 12'h300);
        release_slot();

        // phi_l2 overlap flags an error but the pixel still completes
        pix_ready = 1'b1;
        pixel(12'h210, 12'h010, K_OK, 10, -1, 1);
        check_flags();
        step(3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
